// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer
// Byte-wide UART transmitter (8N1) fed through a circular transmit FIFO.
// Each cycle that in_send_en is high queues in_data[7:0]. The serializer pops
// one byte at a time and drives it LSB first on out_tx_serial. When more data
// is queued, frames follow one another with no idle bit between them.
//
// Ports:
//   in_clk          system clock, rising edge
//   in_reset        synchronous active-high reset
//   in_send_en      push strobe (one byte per high cycle)
//   in_data[31:0]   write word; only bits [7:0] are queued
//   out_tx_serial   UART TX line, idle high
//   out_tx_active   high during START / DATA / STOP
//   out_tx_done     one-cycle pulse in the cycle after each stop bit
//   out_fifo_full   queued count == FIFO_DEPTH
//   out_fifo_empty  queued count == 0
//   out_fifo_count  queued bytes, excluding the byte being shifted out
//   out_overflow    sticky flag, set when a push is dropped
module uart_tx_buffer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = $clog2(FIFO_DEPTH)
) (
    input  logic              in_clk,
    input  logic              in_reset,
    input  logic              in_send_en,
    input  logic [31:0]       in_data,
    output logic              out_tx_serial,
    output logic              out_tx_active,
    output logic              out_tx_done,
    output logic              out_fifo_full,
    output logic              out_fifo_empty,
    output logic [ADDR_W:0]   out_fifo_count,
    output logic              out_overflow
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t              state_reg, state_next;
    logic [BAUD_W-1:0]   baud_reg, baud_next;
    logic [2:0]          bit_idx_reg, bit_idx_next;
    logic [7:0]          shift_reg, shift_next;
    logic [ADDR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [ADDR_W:0]     count_reg, count_next;
    logic [7:0]          mem [FIFO_DEPTH];

    logic tx_serial_reg, tx_active_reg, tx_done_reg;
    logic fifo_full_reg, fifo_empty_reg, overflow_reg;

    logic pop, push_ok, bit_end, serial_next, done_next;
    logic unused_data_bits;

    assign unused_data_bits = ^in_data[31:8];

    assign bit_end = (baud_reg == BAUD_LAST);

    // A push into a full FIFO still succeeds when the serializer pops in the
    // same cycle, since a slot frees up at the same edge.
    assign push_ok = in_send_en && ((count_reg != DEPTH_CNT) || pop);

    // Next-state / pop logic for the serializer.
    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        pop          = 1'b0;
        done_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr_reg];
                    baud_next  = '0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                baud_next = bit_end ? '0 : baud_reg + BAUD_ONE;
                if (bit_end) begin
                    state_next   = ST_DATA;
                    bit_idx_next = 3'd0;
                end
            end
            ST_DATA: begin
                baud_next = bit_end ? '0 : baud_reg + BAUD_ONE;
                if (bit_end) begin
                    if (bit_idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                baud_next = bit_end ? '0 : baud_reg + BAUD_ONE;
                if (bit_end) begin
                    done_next = 1'b1;
                    // Chain straight into the next start bit when data waits.
                    if (count_reg != '0) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr_reg];
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The line level is decoded from the next state so the output is a flop
    // that already shows the new bit in the first cycle of that bit.
    always_comb begin
        serial_next = 1'b1;
        case (state_next)
            ST_START: serial_next = 1'b0;
            ST_DATA:  serial_next = shift_next[bit_idx_next];
            default:  serial_next = 1'b1;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop) begin
            count_next = count_reg + CNT_ONE;
        end else if (!push_ok && pop) begin
            count_next = count_reg - CNT_ONE;
        end
    end

    // FIFO storage: not reset; contents are only ever read below count_reg.
    always_ff @(posedge in_clk) begin
        if (!in_reset && push_ok) begin
            mem[wr_ptr_reg] <= in_data[7:0];
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_reg      <= ST_IDLE;
            baud_reg       <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            tx_serial_reg  <= 1'b1;
            tx_active_reg  <= 1'b0;
            tx_done_reg    <= 1'b0;
            fifo_full_reg  <= 1'b0;
            fifo_empty_reg <= 1'b1;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            baud_reg       <= baud_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            count_reg      <= count_next;
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            tx_serial_reg  <= serial_next;
            tx_active_reg  <= (state_next != ST_IDLE);
            tx_done_reg    <= done_next;
            fifo_full_reg  <= (count_next == DEPTH_CNT);
            fifo_empty_reg <= (count_next == '0);
            if (in_send_en && !push_ok) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign out_tx_serial  = tx_serial_reg;
    assign out_tx_active  = tx_active_reg;
    assign out_tx_done    = tx_done_reg;
    assign out_fifo_full  = fifo_full_reg;
    assign out_fifo_empty = fifo_empty_reg;
    assign out_fifo_count = count_reg;
    assign out_overflow   = overflow_reg;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Testbench for uart_tx_buffer (CLKS_PER_BIT=4, FIFO_DEPTH=16).
// A queue-based reference model predicts every output in every cycle; table
// vectors and hand-written sequences add explicit frame-level checks.
module tb_uart_tx_buffer;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int FRAME = 10 * CPB;

    logic          clk;
    logic          in_reset;
    logic          in_send_en;
    logic [31:0]   in_data;
    logic          out_tx_serial;
    logic          out_tx_active;
    logic          out_tx_done;
    logic          out_fifo_full;
    logic          out_fifo_empty;
    logic [AW:0]   out_fifo_count;
    logic          out_overflow;

    int errors = 0;
    int checks = 0;

    uart_tx_buffer #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .in_clk        (clk),
        .in_reset      (in_reset),
        .in_send_en    (in_send_en),
        .in_data       (in_data),
        .out_tx_serial (out_tx_serial),
        .out_tx_active (out_tx_active),
        .out_tx_done   (out_tx_done),
        .out_fifo_full (out_fifo_full),
        .out_fifo_empty(out_fifo_empty),
        .out_fifo_count(out_fifo_count),
        .out_overflow  (out_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Queue of pending bytes plus the byte on the wire and the number of
    // cycles elapsed since its start bit began.
    logic [7:0] mq[$];
    bit         m_busy = 0;
    int         m_t    = 0;
    logic [7:0] m_cur  = 8'h00;
    bit         m_done = 0;
    bit         m_ovf  = 0;
    bit         model_valid = 0;

    task automatic model_step();
        bit do_pop;
        do_pop = 0;
        if (in_reset) begin
            mq.delete();
            m_busy = 0; m_t = 0; m_done = 0; m_ovf = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_t++;
                if (m_t == FRAME) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
            if (!m_busy && mq.size() > 0) do_pop = 1;
            if (do_pop) begin
                m_cur  = mq.pop_front();
                m_busy = 1;
                m_t    = 0;
            end
            if (in_send_en) begin
                if (mq.size() < DEPTH) mq.push_back(in_data[7:0]);
                else m_ovf = 1;
            end
        end
    endtask

    function automatic logic [10:0] model_out();
        logic ser;
        int   k;
        ser = 1'b1;
        if (m_busy) begin
            k = m_t / CPB;                 // 0 = start, 1..8 = data, 9 = stop
            if (k == 0) ser = 1'b0;
            else if (k <= 8) ser = m_cur[k-1];
        end
        return {ser, m_busy, m_done, (mq.size() == DEPTH), (mq.size() == 0),
                5'(mq.size()), m_ovf};
    endfunction

    // Compare on the falling edge, then advance the model with the inputs
    // that the next rising edge will sample.
    initial begin
        forever begin
            @(negedge clk);
            if (model_valid)
                check("cycle_outputs",
                      32'({out_tx_serial, out_tx_active, out_tx_done, out_fifo_full,
                           out_fifo_empty, out_fifo_count, out_overflow}),
                      32'(model_out()));
            model_step();
            model_valid = 1;
        end
    end

    // ---------------- capture helpers ----------------
    logic [31:0] push_buf [0:31];
    logic        cap_serial [0:1023];
    logic        cap_active [0:1023];
    logic        cap_done   [0:1023];
    logic        cap_full   [0:1023];
    logic        cap_ovf    [0:1023];
    logic [AW:0] cap_count  [0:1023];

    // Entered just after a rising edge. Edge 0 samples push_buf[0]; entry e
    // of the capture arrays holds the outputs right after edge e.
    task automatic run_seq(input int npush, input int ncap, input int reset_edge);
        for (int e = 0; e <= ncap; e++) begin
            if (e < npush) begin
                in_send_en = 1'b1;
                in_data    = push_buf[e];
            end else begin
                in_send_en = 1'b0;
                in_data    = $urandom();
            end
            in_reset = (e == reset_edge);
            @(posedge clk); #1;
            cap_serial[e] = out_tx_serial;
            cap_active[e] = out_tx_active;
            cap_done[e]   = out_tx_done;
            cap_full[e]   = out_fifo_full;
            cap_ovf[e]    = out_overflow;
            cap_count[e]  = out_fifo_count;
        end
        in_send_en = 1'b0;
        in_reset   = 1'b0;
    endtask

    function automatic logic [7:0] decode(input int s);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = cap_serial[s + CPB * (i + 1) + CPB / 2];
        return b;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while ((out_tx_active || !out_fifo_empty) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", 32'(n < 2000), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic frame_check(input logic [31:0] d, input logic [7:0] exp_byte);
        int lows, ndone, first_done, nact;
        push_buf[0] = d;
        run_seq(1, FRAME + 2, -1);
        lows = 0; ndone = 0; first_done = -1; nact = 0;
        for (int e = 1; e <= CPB; e++) if (cap_serial[e] == 1'b0) lows++;
        for (int e = 0; e <= FRAME + 2; e++) begin
            if (cap_done[e]) begin
                ndone++;
                if (first_done < 0) first_done = e;
            end
            if (cap_active[e]) nact++;
        end
        check("start_bit", 32'(lows), 32'(CPB));
        check("frame_byte", 32'(decode(1)), 32'(exp_byte));
        check("stop_bit", 32'(cap_serial[1 + 9 * CPB + 2]), 32'd1);
        check("done_count", 32'(ndone), 32'd1);
        check("done_edge", 32'(first_done), 32'(FRAME + 1));
        check("active_len", 32'(nact), 32'(FRAME));
        check("active_first", 32'(cap_active[1]), 32'd1);
        $display("frame: data=0x%08h byte=0x%02h done_edge=%0d", d, decode(1), first_done);
    endtask

    typedef struct {
        logic [31:0] data;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs [0:4];

    initial begin
        int lows, acts, dones, ndone;
        int done_e [0:31];
        int burst;

        vecs[0] = '{32'h000000A5, 8'hA5};
        vecs[1] = '{32'hDEADBE3C, 8'h3C};
        vecs[2] = '{32'h00000000, 8'h00};
        vecs[3] = '{32'h123456FF, 8'hFF};
        vecs[4] = '{32'hFFFFFF81, 8'h81};

        // Reset held 3 cycles with random inputs.
        in_reset = 1'b1; in_send_en = 1'b0; in_data = '0;
        for (int i = 0; i < 3; i++) begin
            in_send_en = 1'($urandom());
            in_data    = $urandom();
            @(posedge clk); #1;
        end
        check("reset_values",
              32'({out_tx_serial, out_tx_active, out_tx_done, out_fifo_full,
                   out_fifo_empty, out_fifo_count, out_overflow}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0}));
        in_reset = 1'b0; in_send_en = 1'b0;
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!out_tx_serial || out_tx_active) lows++;
        end
        check("reset_quiet", 32'(lows), 32'd0);
        $display("reset: outputs at reset values");

        // Table-driven single frames.
        for (int v = 0; v < 5; v++) begin
            wait_idle();
            frame_check(vecs[v].data, vecs[v].exp_byte);
        end

        // Back-to-back frames.
        wait_idle();
        push_buf[0] = 32'h11; push_buf[1] = 32'h22; push_buf[2] = 32'h33;
        run_seq(3, 3 * FRAME + 3, -1);
        ndone = 0; acts = 0;
        for (int e = 0; e <= 3 * FRAME + 3; e++) begin
            if (cap_done[e]) begin
                if (ndone < 32) done_e[ndone] = e;
                ndone++;
            end
            if (cap_active[e]) acts++;
        end
        check("b2b_done_count", 32'(ndone), 32'd3);
        check("b2b_done0", 32'(done_e[0]), 32'(FRAME + 1));
        check("b2b_done1", 32'(done_e[1]), 32'(2 * FRAME + 1));
        check("b2b_done2", 32'(done_e[2]), 32'(3 * FRAME + 1));
        check("b2b_active", 32'(acts), 32'(3 * FRAME));
        check("b2b_start2", 32'(cap_serial[FRAME + 1]), 32'd0);
        check("b2b_byte0", 32'(decode(1)), 32'h11);
        check("b2b_byte1", 32'(decode(FRAME + 1)), 32'h22);
        check("b2b_byte2", 32'(decode(2 * FRAME + 1)), 32'h33);
        check("b2b_count_before", 32'(cap_count[2 * FRAME]), 32'd1);
        check("b2b_count_after", 32'(cap_count[2 * FRAME + 1]), 32'd0);
        $display("back_to_back: done edges %0d %0d %0d", done_e[0], done_e[1], done_e[2]);

        // Overflow: 18 consecutive pushes.
        wait_idle();
        for (int i = 0; i < 18; i++) push_buf[i] = 32'(i);
        run_seq(18, 17 * FRAME + 3, -1);
        check("ovf_count16", 32'(cap_count[16]), 32'd16);
        check("ovf_full16", 32'(cap_full[16]), 32'd1);
        check("ovf_clear16", 32'(cap_ovf[16]), 32'd0);
        check("ovf_set17", 32'(cap_ovf[17]), 32'd1);
        check("ovf_count17", 32'(cap_count[17]), 32'd16);
        check("ovf_sticky", 32'(cap_ovf[17 * FRAME + 3]), 32'd1);
        ndone = 0;
        for (int e = 0; e <= 17 * FRAME + 3; e++) if (cap_done[e]) ndone++;
        check("ovf_frames", 32'(ndone), 32'd17);
        for (int i = 0; i < 17; i++) check("ovf_byte", 32'(decode(1 + FRAME * i)), 32'(i));
        check("ovf_idle_end", 32'(cap_active[17 * FRAME + 2]), 32'd0);
        $display("overflow: 17 frames sent, overflow=%0b", cap_ovf[17 * FRAME + 3]);

        // Reset during DATA bit 3 of the first of three frames.
        push_buf[0] = 32'h5A; push_buf[1] = 32'h6B; push_buf[2] = 32'h7C;
        run_seq(3, 18 + 100, 18);
        check("mid_active_before", 32'(cap_active[17]), 32'd1);
        check("mid_serial", 32'(cap_serial[18]), 32'd1);
        check("mid_active", 32'(cap_active[18]), 32'd0);
        check("mid_count", 32'(cap_count[18]), 32'd0);
        check("mid_ovf_cleared", 32'(cap_ovf[18]), 32'd0);
        lows = 0; acts = 0; dones = 0;
        for (int e = 19; e <= 118; e++) begin
            if (!cap_serial[e]) lows++;
            if (cap_active[e]) acts++;
            if (cap_done[e]) dones++;
        end
        check("mid_quiet_serial", 32'(lows), 32'd0);
        check("mid_quiet_active", 32'(acts), 32'd0);
        check("mid_quiet_done", 32'(dones), 32'd0);
        $display("reset_mid_frame: line idle for 100 cycles");
        frame_check(32'h000000C3, 8'hC3);

        // Randomized traffic checked against the model each cycle.
        burst = 0;
        for (int c = 0; c < 3000; c++) begin
            if (burst == 0 && $urandom_range(0, 299) == 0) burst = $urandom_range(5, 24);
            in_reset   = ($urandom_range(0, 599) == 0);
            in_send_en = (burst > 0) || ($urandom_range(0, 39) == 0);
            in_data    = $urandom();
            if (burst > 0) burst--;
            @(posedge clk); #1;
        end
        in_send_en = 1'b0; in_reset = 1'b0;
        wait_idle();
        $display("random: 3000 cycles of traffic compared against model");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Byte-oriented UART transmitter with a transmit FIFO, directly downstream of the MMIO mapper. It consumes the mapper's UART transmit strobe and data word, queues the low byte of each write, and serializes queued bytes as 8N1 frames on the TX line. It exports `tx_active` and `tx_done` for the mapper's UART status input, plus FIFO status flags.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200); minimum 2.
- `FIFO_DEPTH`, default 16: FIFO entries; must be a power of two, minimum 2.
- `ADDR_W`, default $clog2(FIFO_DEPTH): FIFO pointer width; derived, do not override.

Ports:
- `in_clk`  input  1  system clock; all logic on the rising edge.
- `in_reset`  input  1  synchronous, active-high reset.
- `in_send_en`  input  1  push strobe. Each cycle it is sampled high pushes one byte.
- `in_data`  input  32  write word. Bits [7:0] are pushed; bits [31:8] are ignored.
- `out_tx_serial`  output  1  UART TX line; idle high.
- `out_tx_active`  output  1  high while a frame is in progress (START, DATA or STOP).
- `out_tx_done`  output  1  one-cycle pulse after each stop bit completes.
- `out_fifo_full`  output  1  count == FIFO_DEPTH.
- `out_fifo_empty`  output  1  count == 0.
- `out_fifo_count`  output  ADDR_W+1  number of queued bytes; excludes the byte being shifted out.
- `out_overflow`  output  1  sticky; set when a push is dropped; cleared only by reset.

## Operation
- All outputs are registered.
- Reset values: `out_tx_serial`=1, `out_tx_active`=0, `out_tx_done`=0, `out_fifo_full`=0, `out_fifo_empty`=1, `out_fifo_count`=0, `out_overflow`=0. Reset also clears the pointers, the state and the baud counter.
- FIFO: circular buffer with ADDR_W-bit read and write pointers that wrap modulo FIFO_DEPTH, and a separate count.
  - Push when not full: write `in_data[7:0]` at the write pointer.
  - Push when full with no pop in the same cycle: drop the byte and set `out_overflow`.
  - Push and pop in the same cycle: both succeed, count is unchanged. This holds when full, so the push is not dropped.
  - Pop when empty never occurs; the FSM pops only when not empty.
- FSM states:
  - IDLE: serial=1. If the FIFO is not empty, pop into the shift register, clear the baud counter and go to START.
  - START: serial=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: serial=shift[index], LSB first, CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: serial=1 for CLKS_PER_BIT cycles. On the final cycle, pulse `out_tx_done` next cycle. If the FIFO is not empty, pop and go directly to START (no idle bit). Otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and resets at each bit boundary.
- `out_tx_active` is 1 exactly while the state is START, DATA or STOP.

## Timing
- Push latency: `in_send_en` sampled at edge k makes the count 1 after edge k. With an idle FSM, the pop happens at edge k+1 and `out_tx_serial` goes low after edge k+1.
- Frame length: 10×CLKS_PER_BIT cycles from the start-bit falling edge to the end of the stop bit.
- `out_tx_done` is high for exactly one cycle, the first cycle after the stop bit. On a back-to-back frame that cycle is also the first start-bit cycle.
- Back-to-back frames: start-bit edges are exactly 10×CLKS_PER_BIT cycles apart.
- Capacity: FIFO_DEPTH queued bytes plus one in the shift register.
- Reset mid-frame: the cycle after the reset edge, `out_tx_serial`=1 and `out_tx_active`=0. Queued bytes are discarded, and no partial frame resumes.
- Reset has priority over push and pop in the same cycle.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=16.
- Reset: hold `in_reset` 3 cycles with random `in_send_en`/`in_data` -> all outputs at reset values, nothing transmitted.
- Single byte: push 0x000000A5 at edge 0 -> serial 0 from edge 1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop 1. `out_tx_done` pulses at edge 41. `out_tx_active` is high for edges 1..40.
- Upper bits ignored: push 0xDEADBE3C -> frame carries 0x3C (bits 0,0,1,1,1,1,0,0).
- Back-to-back: push 0x11, 0x22, 0x33 on consecutive cycles -> three frames with start edges 40 cycles apart, no idle gap, three `out_tx_done` pulses, count reaches 0 after the third pop.
- Overflow: 18 consecutive pushes 0x00..0x11 -> after the 17th push, count=16 and full=1. The 18th push (0x11) is dropped, `out_overflow`=1 and stays 1. Bytes 0x00..0x10 are transmitted in order.
- Reset mid-frame: push 3 bytes, assert reset during DATA bit 3 of the first -> serial 1 and count 0 next cycle. No frames for the following 100 cycles. A new push then transmits normally.
